tick_scheduler: RTL and testbench

- Shares one free-running prescaler among NUM_CH timer channels.
- Each channel has a programmable period, counted in base ticks, and a one-shot or periodic mode.
- Expiries are queued per channel and dispatched as single-cycle enable pulses, one channel per clock, in round-robin order.
- Sits between control logic and the pulse-driven blocks, and replaces one free-running enable generator per consumer.

---
 rtl/tick_scheduler.sv | 151 +++++++++++++++
 tb/tb_tick_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared-prescaler timer bank: NUM_CH programmable channels whose expiries are
// queued (depth 1) and dispatched as one-cycle enable pulses in round-robin order.
module tick_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int PRESCALE = 100000,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]          cfg_period,
   input  logic                      cfg_oneshot,
   input  logic [NUM_CH-1:0]         ch_start,
   input  logic [NUM_CH-1:0]         ch_stop,
   input  logic                      overrun_clr,
   output logic                      tick,
   output logic [NUM_CH-1:0]         enable,
   output logic [NUM_CH-1:0]         ch_active,
   output logic [NUM_CH-1:0]         overrun,
   output logic                      dbg_state
);

   localparam int CW = $clog2(NUM_CH);
   localparam int PW = $clog2(PRESCALE);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [PW-1:0]                  presc_q, presc_d;
   logic                           tick_q, tick_d;
   logic [NUM_CH-1:0]              enable_q, enable_d;
   logic [NUM_CH-1:0]              active_q, active_d;
   logic [NUM_CH-1:0]              pending_q, pending_d;
   logic [NUM_CH-1:0]              overrun_q, overrun_d;
   logic [NUM_CH-1:0]              oneshot_q, oneshot_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   period_q, period_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   count_q, count_d;
   logic [CW-1:0]                  rr_q, rr_d;
   logic [0:0]                     state_q, state_d;

   logic                           grant, found;
   logic [CW:0]                    idx;
   logic [CW-1:0]                  sel;
   logic [NUM_CH-1:0]              dispatch;
   logic [NUM_CH-1:0]              cfg_hit, stop_v, start_v, match_v, expire_v, ovr_set;

   always_comb begin
      presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;
      tick_d  = (presc_q == PW'(PRESCALE - 1));
   end

   // Round-robin search starting at rr_q, wrapping modulo NUM_CH.
   always_comb begin
      grant = (state_q == ST_GRANT);
      sel   = rr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = {1'b0, rr_q} + (CW+1)'(k);
         if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
         if (!found && pending_q[idx[CW-1:0]]) begin
            sel   = idx[CW-1:0];
            found = 1'b1;
         end
      end
      dispatch = '0;
      rr_d     = rr_q;
      if (grant && found) begin
         dispatch[sel] = 1'b1;
         rr_d          = (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
      end
      enable_d = dispatch;
   end

   // Priority per channel: stop > start > tick counting.
   always_comb begin
      period_d  = period_q;
      oneshot_d = oneshot_q;
      count_d   = count_q;
      active_d  = active_q;
      pending_d = pending_q;
      cfg_hit   = '0;
      stop_v    = '0;
      start_v   = '0;
      match_v   = '0;
      expire_v  = '0;
      ovr_set   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit[i]  = cfg_we && (cfg_ch == CW'(i));
         stop_v[i]   = ch_stop[i] || (cfg_hit[i] && (cfg_period == '0) && active_q[i]);
         start_v[i]  = ch_start[i] && (period_q[i] != '0);
         match_v[i]  = (count_q[i] >= period_q[i] - 1'b1);
         expire_v[i] = tick_q && active_q[i] && !stop_v[i] && !start_v[i] && match_v[i];
         ovr_set[i]  = expire_v[i] && pending_q[i] && !dispatch[i];
         if (cfg_hit[i]) begin
            period_d[i]  = cfg_period;
            oneshot_d[i] = cfg_oneshot;
         end
         if (stop_v[i]) begin
            active_d[i] = 1'b0;
            count_d[i]  = '0;
         end else if (start_v[i]) begin
            active_d[i] = 1'b1;
            count_d[i]  = '0;
         end else if (tick_q && active_q[i]) begin
            count_d[i] = match_v[i] ? '0 : count_q[i] + 1'b1;
            if (match_v[i] && oneshot_q[i]) active_d[i] = 1'b0;
         end
         if (stop_v[i])        pending_d[i] = 1'b0;
         else if (expire_v[i]) pending_d[i] = 1'b1;
         else if (dispatch[i]) pending_d[i] = 1'b0;
      end
      overrun_d = (overrun_q & ~{NUM_CH{overrun_clr}}) | ovr_set;
      state_d   = (pending_d != '0) ? ST_GRANT : ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         tick_q    <= 1'b0;
         enable_q  <= '0;
         active_q  <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         oneshot_q <= '0;
         period_q  <= '0;
         count_q   <= '0;
         rr_q      <= '0;
         state_q   <= ST_IDLE;
      end else begin
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         enable_q  <= enable_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         oneshot_q <= oneshot_d;
         period_q  <= period_d;
         count_q   <= count_d;
         rr_q      <= rr_d;
         state_q   <= state_d;
      end
   end

   assign tick      = tick_q;
   assign enable    = enable_q;
   assign ch_active = active_q;
   assign overrun   = overrun_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: one instance at PRESCALE=4 feeds an enable scoreboard,
// a second at PRESCALE=2 shares all inputs and is used for the overrun scenario.
`timescale 1ns/1ps
module tb_tick_scheduler;

   localparam int NCH = 4;
   localparam int EW  = 32 + NCH;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_we = 1'b0;
   logic [1:0]      cfg_ch = '0;
   logic [15:0]     cfg_period = '0;
   logic            cfg_oneshot = 1'b0;
   logic [NCH-1:0]  ch_start = '0;
   logic [NCH-1:0]  ch_stop = '0;
   logic            overrun_clr = 1'b0;

   logic            tick, tick2;
   logic [NCH-1:0]  enable, enable2, ch_active, ch_active2, overrun, overrun2;
   logic            dbg_state, dbg_state2;

   int              cyc = 0;
   int              rel = 0;
   int              checks = 0;
   int              errors = 0;
   bit              mon_en = 1'b0;
   logic [EW-1:0]   exp_q[$];

   tick_scheduler #(.NUM_CH(NCH), .PRESCALE(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .cfg_oneshot(cfg_oneshot), .ch_start(ch_start), .ch_stop(ch_stop), .overrun_clr(overrun_clr),
      .tick(tick), .enable(enable), .ch_active(ch_active), .overrun(overrun), .dbg_state(dbg_state)
   );

   tick_scheduler #(.NUM_CH(NCH), .PRESCALE(2), .CNT_W(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
      .cfg_oneshot(cfg_oneshot), .ch_start(ch_start), .ch_stop(ch_stop), .overrun_clr(overrun_clr),
      .tick(tick2), .enable(enable2), .ch_active(ch_active2), .overrun(overrun2), .dbg_state(dbg_state2)
   );

   // Clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
      $fatal(1);
   end

   // Scoreboard: every enable pulse must match the head of exp_q (cycle and one-hot value).
   always @(negedge clk) begin
      if (mon_en && enable !== '0) begin
         logic [EW-1:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL enable_unexpected: got cyc=%0d enable=%b, expected no pulse", cyc - rel, enable);
         end else begin
            e = exp_q.pop_front();
            if ({cyc, enable} !== e) begin
               errors++;
               $display("FAIL enable_seq: got off=%0d enable=%b, expected off=%0d enable=%b",
                        cyc - rel, enable, int'(e[EW-1:NCH]) - rel, e[NCH-1:0]);
            end
         end
      end
   end

   // Driver tasks
   task automatic wait_until(input int off);
      while (cyc < rel + off) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; cfg_we = 1'b0; ch_start = '0; ch_stop = '0; overrun_clr = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      mon_en = 1'b1;
   endtask

   task automatic cfg_write(input int off, input int ch, input int per, input bit os);
      wait_until(off);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 16'(per); cfg_oneshot = os;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse(input int off, input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
      wait_until(off);
      ch_start = st; ch_stop = sp;
      @(negedge clk);
      ch_start = '0; ch_stop = '0;
   endtask

   task automatic expect_en(input int off, input logic [NCH-1:0] m);
      exp_q.push_back({32'(rel + off), m});
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: %0d expected enables never seen, expected 0 left", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Tests
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tick, enable, ch_active, overrun, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got tick=%b en=%b act=%b ovr=%b st=%b, expected all 0",
                  tick, enable, ch_active, overrun, dbg_state);
      end
      checks++;
      if ({tick2, enable2, ch_active2, overrun2, dbg_state2} !== '0) begin
         errors++;
         $display("FAIL reset_outputs2: got tick=%b en=%b act=%b ovr=%b, expected all 0",
                  tick2, enable2, ch_active2, overrun2);
      end
      rst_n = 1'b1;
      rel = cyc;
   endtask

   task automatic test_periodic();
      logic exp_tick[3] = '{1'b0, 1'b1, 1'b0};
      do_reset();
      cfg_write(0, 0, 3, 1'b0);
      pulse(1, 4'b0001, 4'b0000);
      expect_en(14, 4'b0001);
      expect_en(26, 4'b0001);
      expect_en(38, 4'b0001);
      for (int k = 0; k < 3; k++) begin
         wait_until(3 + k);
         checks++;
         if (tick !== exp_tick[k]) begin
            errors++;
            $display("FAIL tick_phase: off=%0d got tick=%b, expected %b", 3 + k, tick, exp_tick[k]);
         end
      end
      wait_until(13);
      checks++;
      if (dbg_state !== 1'b1) begin
         errors++; $display("FAIL fsm_grant: got state=%b, expected 1", dbg_state);
      end
      wait_until(14);
      checks++;
      if (dbg_state !== 1'b0) begin
         errors++; $display("FAIL fsm_idle: got state=%b, expected 0", dbg_state);
      end
      pulse(40, 4'b0000, 4'b0001);
      wait_until(55);
      check_drained("periodic");
   endtask

   task automatic test_all_channels();
      do_reset();
      for (int c = 0; c < NCH; c++) cfg_write(c, c, 2, 1'b0);
      pulse(5, 4'b1111, 4'b0000);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NCH; c++) expect_en(14 + 8 * r + c, 4'(1 << c));
      pulse(28, 4'b0000, 4'b1111);
      wait_until(30);
      checks++;
      if (overrun !== 4'b0000) begin
         errors++; $display("FAIL all_ch_overrun: got %b, expected 0000", overrun);
      end
      wait_until(40);
      check_drained("all_channels");
   endtask

   task automatic test_round_robin();
      do_reset();
      cfg_write(0, 0, 2, 1'b0);
      cfg_write(1, 2, 1, 1'b0);
      cfg_write(2, 3, 2, 1'b0);
      pulse(5, 4'b1101, 4'b0000);
      expect_en(10, 4'b0100);
      expect_en(14, 4'b1000);
      expect_en(15, 4'b0001);
      expect_en(16, 4'b0100);
      expect_en(18, 4'b0100);
      pulse(19, 4'b0000, 4'b1111);
      wait_until(30);
      check_drained("round_robin");
   endtask

   task automatic test_oneshot();
      do_reset();
      cfg_write(0, 1, 5, 1'b1);
      pulse(1, 4'b0010, 4'b0000);
      expect_en(22, 4'b0010);
      wait_until(20);
      checks++;
      if (ch_active[1] !== 1'b1) begin
         errors++; $display("FAIL oneshot_active: got %b, expected 1", ch_active[1]);
      end
      wait_until(21);
      checks++;
      if (ch_active[1] !== 1'b0) begin
         errors++; $display("FAIL oneshot_fall: got %b, expected 0", ch_active[1]);
      end
      wait_until(21 + 160);
      checks++;
      if (ch_active !== 4'b0000 || overrun !== 4'b0000) begin
         errors++; $display("FAIL oneshot_end: got act=%b ovr=%b, expected 0000 0000", ch_active, overrun);
      end
      check_drained("oneshot");
   endtask

   task automatic test_overrun();
      logic [NCH-1:0] exp_en[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      do_reset();
      mon_en = 1'b0;
      for (int c = 0; c < NCH; c++) cfg_write(c, c, 1, 1'b0);
      pulse(5, 4'b1111, 4'b0000);
      wait_until(7);
      checks++;
      if (ch_active2 !== 4'b1111) begin
         errors++; $display("FAIL ovr_active: got %b, expected 1111", ch_active2);
      end
      for (int k = 0; k < 4; k++) begin
         wait_until(8 + k);
         checks++;
         if (enable2 !== exp_en[k]) begin
            errors++; $display("FAIL ovr_dispatch: off=%0d got enable=%b, expected %b", 8 + k, enable2, exp_en[k]);
         end
         if (k == 1) begin
            checks++;
            if (overrun2 !== 4'b1100) begin
               errors++; $display("FAIL ovr_set: got overrun=%b, expected 1100", overrun2);
            end
         end
         if (k == 2) overrun_clr = 1'b1;
         if (k == 3) begin
            overrun_clr = 1'b0;
            checks++;
            if (overrun2 !== 4'b0011) begin
               errors++; $display("FAIL ovr_clr_vs_set: got overrun=%b, expected 0011", overrun2);
            end
         end
      end
      pulse(11, 4'b0000, 4'b1111);
      wait_until(13);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      checks++;
      if (overrun2 !== 4'b0000 || ch_active2 !== 4'b0000) begin
         errors++; $display("FAIL ovr_cleared: got ovr=%b act=%b, expected 0000 0000", overrun2, ch_active2);
      end
   endtask

   task automatic test_start_stop();
      do_reset();
      cfg_write(0, 0, 10, 1'b0);
      cfg_write(1, 2, 1, 1'b0);
      pulse(2, 4'b0101, 4'b0000);
      wait_until(4);
      checks++;
      if (ch_active[2] !== 1'b1) begin
         errors++; $display("FAIL ss_running: got %b, expected 1", ch_active[2]);
      end
      pulse(4, 4'b0100, 4'b0100);
      checks++;
      if (ch_active[2] !== 1'b0) begin
         errors++; $display("FAIL ss_stop_wins: got %b, expected 0", ch_active[2]);
      end
      expect_en(18, 4'b0001);
      expect_en(26, 4'b0001);
      cfg_write(13, 0, 2, 1'b0);
      cfg_write(27, 0, 0, 1'b0);
      checks++;
      if (ch_active[0] !== 1'b0) begin
         errors++; $display("FAIL ss_period0_stop: got %b, expected 0", ch_active[0]);
      end
      pulse(29, 4'b1001, 4'b0000);
      checks++;
      if (ch_active !== 4'b0000) begin
         errors++; $display("FAIL ss_start_period0: got %b, expected 0000", ch_active);
      end
      wait_until(40);
      check_drained("start_stop");
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      for (int c = 0; c < NCH; c++) cfg_write(c, c, 1, 1'b0);
      pulse(5, 4'b1111, 4'b0000);
      expect_en(10, 4'b0001);
      wait_until(10);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({enable, ch_active, overrun, dbg_state, tick} !== '0) begin
         errors++;
         $display("FAIL rst_mid_grant: got en=%b act=%b ovr=%b st=%b tick=%b, expected all 0",
                  enable, ch_active, overrun, dbg_state, tick);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      for (int k = 3; k <= 4; k++) begin
         wait_until(k);
         checks++;
         if (tick !== (k == 4)) begin
            errors++; $display("FAIL rst_first_tick: off=%0d got tick=%b, expected %b", k, tick, k == 4);
         end
      end
      wait_until(24);
      check_drained("reset_mid_grant");
   endtask

   // Sequence and report
   initial begin
      test_reset();
      test_periodic();
      test_all_channels();
      test_round_robin();
      test_oneshot();
      test_overrun();
      test_start_stop();
      test_reset_mid_grant();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
